go_encode: RTL and testbench
============================

// Module: go_encode
// PURPOSE
// Sequential tic-tac-toe game-over encoder. On start, scans the 9 board cells through a 1-cycle-latency read port.
// It checks all 8 winning lines and draw, then registers the gameover[9:0] vector that the display-side decoder consumes.
// Sits between the board RAM/register file and the VGA colour path; one scan per move.
// PARAMETERS
// X_CODE  2'b01  cell code for player X
// O_CODE  2'b10  cell code for player O (any other code, incl. 2'b00/2'b11, = empty)
// PORTS
// clk       in   1   system clock
// rst       in   1   synchronous, active-high reset
// start     in   1   1-cycle pulse: begin scan (ignored while busy)
// rd_addr   out  4   cell address {row[1:0],col[1:0]}; valid 0,1,2,4,5,6,8,9,A
// rd_data   in   2   cell code for rd_addr, valid 1 cycle after rd_addr
// busy      out  1   scan in progress
// done      out  1   1-cycle pulse: gameover/winner updated this cycle
// gameover  out  10  [0..2] rows 0-2; [3..5] cols 0-2; [6] diag 0,5,A; [7] anti-diag 2,5,8; [8] draw; [9] game over
// winner    out  2   X_CODE / O_CODE of winning player, 2'b00 if none/draw
// BEHAVIOUR
// - Reset: state IDLE, rd_addr=0, busy=0, done=0, gameover=0, winner=0, cell regs cleared. Reset mid-scan aborts the scan; no done.
// - FSM IDLE -> READ (9 cycles) -> WAIT (1) -> EVAL (1) -> IDLE.
// - start sampled high in IDLE at edge T: READ occupies cycles T+1..T+9, rd_addr = 0,1,2,4,5,6,8,9,A in order.
// - rd_data captured at end of cycle following each address (T+2..T+10); WAIT covers the last capture.
// - EVAL at T+11 computes lines from captured cells; outputs registered at end of T+11.
// - done=1 for exactly cycle T+12, with new gameover/winner visible. busy=1 cycles T+1..T+11.
// - Line bit n set iff all 3 cells of line n equal the winning player's code.
// - X and O both complete lines (illegal board): X wins, only X lines set, winner=X_CODE.
// - Multiple lines of the winner: all corresponding bits set (e.g. bits 0 and 6 together).
// - Draw: all 9 cells non-empty and no line: gameover=10'h300, winner=0.
// - No win, not full: gameover=10'h000, winner=0. bit9 = OR(bits 0..8) always.
// - start while busy: ignored, no queuing. start in same cycle as done: accepted (state is IDLE).
// - gameover/winner hold between scans; each completed scan overwrites both fully.
// - rd_addr holds last value (A) outside READ; never emits 3,7,B..F.
// CONFIGURATION
// GO_ENCODE_STICKY_EN defined: once gameover[9]=1, later start pulses are ignored (no scan, no busy, no done).
//   gameover/winner stay frozen until rst.
// Not defined: every start in IDLE performs a full scan and overwrites results, including clearing gameover[9].
// TESTING
// 1 Empty board (all 2'b00), start -> done at T+12, gameover=10'h000, winner=0, busy high exactly T+1..T+11.
// 2 X on 0,1,2 and X on 0,5,A, rest O/empty -> gameover=10'h241, winner=2'b01.
// 3 O on 2,6,A (col 2) -> gameover=10'h220, winner=2'b10; X on 0,4,8 simultaneously -> gameover=10'h208, winner=X.
// 4 Full board X O X / X O O / O X X -> gameover=10'h300, winner=0.
// 5 Assert rst at T+5 of a scan -> no done, all outputs 0 next cycle. start while busy -> ignored, single done.
// 6 With GO_ENCODE_STICKY_EN: win, clear board, start -> no busy/done, gameover unchanged. Without it -> gameover=0.

Source files
------------

// File: rtl/go_encode.sv
// rtl/go_encode.sv - tic-tac-toe game-over encoder scanning 9 cells via 1-cycle read port
// Optional GO_ENCODE_STICKY_EN: freeze results once a game-over is flagged until rst.
module go_encode #(
    parameter logic [1:0] X_CODE = 2'b01,
    parameter logic [1:0] O_CODE = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic [9:0] gameover,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, EVAL} state_t;

    state_t     state, state_n;
    logic [3:0] idx;
    logic       cap_en;
    logic [3:0] cap_idx;
    logic [1:0] cells [9];
    logic       accept;
    logic [7:0] x_line, o_line;
    logic       full;
    logic [9:0] go_n;
    logic [1:0] win_n;

`ifdef GO_ENCODE_STICKY_EN
    assign accept = start && !gameover[9];
`else
    assign accept = start;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = READ;
            READ:    if (idx == 4'd8) state_n = WAIT;
            WAIT:    state_n = EVAL;
            EVAL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    function automatic logic all3(input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] c, input logic [1:0] code);
        return (a == code) && (b == code) && (c == code);
    endfunction

    // cells[] is indexed by scan order (row-major 0..8), not by board address
    always_comb begin
        x_line = '0;
        o_line = '0;
        full   = 1'b1;
        go_n   = '0;
        win_n  = 2'b00;
        for (int r = 0; r < 3; r++) begin
            x_line[r]   = all3(cells[3*r], cells[3*r+1], cells[3*r+2], X_CODE);
            o_line[r]   = all3(cells[3*r], cells[3*r+1], cells[3*r+2], O_CODE);
            x_line[3+r] = all3(cells[r], cells[r+3], cells[r+6], X_CODE);
            o_line[3+r] = all3(cells[r], cells[r+3], cells[r+6], O_CODE);
        end
        x_line[6] = all3(cells[0], cells[4], cells[8], X_CODE);
        o_line[6] = all3(cells[0], cells[4], cells[8], O_CODE);
        x_line[7] = all3(cells[2], cells[4], cells[6], X_CODE);
        o_line[7] = all3(cells[2], cells[4], cells[6], O_CODE);
        for (int i = 0; i < 9; i++) begin
            if (cells[i] != X_CODE && cells[i] != O_CODE) full = 1'b0;
        end
        // X takes priority on an illegal board where both players have lines
        if (|x_line) begin
            go_n  = {2'b10, x_line};
            win_n = X_CODE;
        end else if (|o_line) begin
            go_n  = {2'b10, o_line};
            win_n = O_CODE;
        end else if (full) begin
            go_n  = 10'h300;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr  <= '0;
            idx      <= '0;
            cap_en   <= 1'b0;
            cap_idx  <= '0;
            done     <= 1'b0;
            gameover <= '0;
            winner   <= '0;
            for (int i = 0; i < 9; i++) cells[i] <= '0;
        end else begin
            done    <= 1'b0;
            cap_en  <= (state == READ);
            cap_idx <= idx;
            if (state == IDLE && accept) begin
                rd_addr <= '0;
                idx     <= '0;
            end else if (state == READ && idx != 4'd8) begin
                idx <= idx + 4'd1;
                if (rd_addr[1:0] == 2'd2) rd_addr <= {rd_addr[3:2] + 2'd1, 2'b00};
                else                      rd_addr <= rd_addr + 4'd1;
            end
            if (cap_en) cells[cap_idx] <= rd_data;
            if (state == EVAL) begin
                done     <= 1'b1;
                gameover <= go_n;
                winner   <= win_n;
            end
        end
    end

endmodule

// File: tb/tb_go_encode.sv
// tb/tb_go_encode.sv - self-checking bench for go_encode with board RAM and reference model
module tb_go_encode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy, done;
    logic [9:0] gameover;
    logic [1:0] winner;

    go_encode dut (
        .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .gameover(gameover), .winner(winner)
    );

    always #5 clk = ~clk;

    logic [1:0] mem [16];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int checks = 0;
    int errors = 0;
    bit armed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: board addresses of the 8 lines, bit order of gameover[7:0]
    int lines [8][3] = '{'{0,1,2}, '{4,5,6}, '{8,9,10}, '{0,4,8},
                         '{1,5,9}, '{2,6,10}, '{0,5,10}, '{2,5,8}};
    int seq [9] = '{0,1,2,4,5,6,8,9,10};

    function automatic logic [11:0] judge();
        logic [7:0] xb, ob;
        bit full;
        xb = '0; ob = '0; full = 1;
        for (int l = 0; l < 8; l++) begin
            xb[l] = (mem[lines[l][0]] == 2'b01) && (mem[lines[l][1]] == 2'b01) && (mem[lines[l][2]] == 2'b01);
            ob[l] = (mem[lines[l][0]] == 2'b10) && (mem[lines[l][1]] == 2'b10) && (mem[lines[l][2]] == 2'b10);
        end
        for (int i = 0; i < 9; i++)
            if (mem[seq[i]] != 2'b01 && mem[seq[i]] != 2'b10) full = 0;
        if (xb != 0)   return {2'b01, 2'b10, xb};
        if (ob != 0)   return {2'b10, 2'b10, ob};
        if (full)      return {2'b00, 10'h300};
        return 12'h000;
    endfunction

    // ph = cycles since accepted start (0 = idle, 12 = done cycle)
    int         ph = 0;
    logic [3:0] exp_addr = 0;
    logic [9:0] exp_go = 0;
    logic [1:0] exp_win = 0;

    function automatic bit sticky_block();
`ifdef GO_ENCODE_STICKY_EN
        return exp_go[9];
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; exp_addr = 0; exp_go = 0; exp_win = 0;
        end else if ((ph == 0 || ph == 12) && start && !sticky_block()) begin
            ph = 1; exp_addr = 0;
        end else if (ph == 12) begin
            ph = 0;
        end else if (ph > 0) begin
            ph++;
            if (ph <= 9) exp_addr = 4'(seq[ph-1]);
            if (ph == 12) {exp_win, exp_go} = judge();
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(busy), 32'(ph >= 1 && ph <= 11));
            chk("done", 32'(done), 32'(ph == 12));
            chk("gameover", 32'(gameover), 32'(exp_go));
            chk("winner", 32'(winner), 32'(exp_win));
            chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // Pulse start, then watch cycles T+1..T+13
    task automatic scan(output int nbusy, output int ndone, output int done_at);
        nbusy = 0; ndone = 0; done_at = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) nbusy++;
            if (done) begin ndone++; done_at = c; end
        end
    endtask

    int nb, nd, da;

    initial begin
        clear_board();
        rst = 1'b1;
        @(negedge clk);
        armed = 1;
        chk("reset_gameover", 32'(gameover), 32'h0);
        chk("reset_rd_addr", 32'(rd_addr), 32'h0);
        @(negedge clk) rst = 1'b0;

        // 1 empty board
        scan(nb, nd, da);
        chk("t1_busy_cycles", 32'(nb), 32'd11);
        chk("t1_done_at_T12", 32'(da), 32'd12);
        chk("t1_gameover", 32'(gameover), 32'h000);

        // 2 X row 0 and diagonal
        pulse_reset();
        clear_board();
        mem[0] = 2'b01; mem[1] = 2'b01; mem[2] = 2'b01;
        mem[4] = 2'b10; mem[5] = 2'b01; mem[6] = 2'b10;
        mem[8] = 2'b10; mem[9] = 2'b10; mem[10] = 2'b01;
        scan(nb, nd, da);
        chk("t2_model", 32'(exp_go), 32'h241);
        chk("t2_gameover", 32'(gameover), 32'h241);
        chk("t2_winner", 32'(winner), 32'h1);

        // 3 O column 2, then X column 0 added
        pulse_reset();
        clear_board();
        mem[2] = 2'b10; mem[6] = 2'b10; mem[10] = 2'b10;
        scan(nb, nd, da);
        chk("t3a_gameover", 32'(gameover), 32'h220);
        chk("t3a_winner", 32'(winner), 32'h2);
        pulse_reset();
        mem[0] = 2'b01; mem[4] = 2'b01; mem[8] = 2'b01;
        scan(nb, nd, da);
        chk("t3b_model", 32'(exp_go), 32'h208);
        chk("t3b_gameover", 32'(gameover), 32'h208);
        chk("t3b_winner", 32'(winner), 32'h1);

        // 4 draw: X O X / X O O / O X X
        pulse_reset();
        mem[0] = 2'b01; mem[1] = 2'b10; mem[2] = 2'b01;
        mem[4] = 2'b01; mem[5] = 2'b10; mem[6] = 2'b10;
        mem[8] = 2'b10; mem[9] = 2'b01; mem[10] = 2'b01;
        scan(nb, nd, da);
        chk("t4_gameover", 32'(gameover), 32'h300);
        chk("t4_winner", 32'(winner), 32'h0);

        // 5 reset mid-scan, then start while busy
        pulse_reset();
        clear_board();
        mem[0] = 2'b01; mem[1] = 2'b01; mem[2] = 2'b01;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("t5_rst_gameover", 32'(gameover), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        nd = 0;
        repeat (14) begin @(negedge clk); if (done) nd++; end
        chk("t5_no_done", 32'(nd), 32'd0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        nd = 0;
        repeat (20) begin @(negedge clk); if (done) nd++; end
        chk("t5_single_done", 32'(nd), 32'd1);
        chk("t5_gameover", 32'(gameover), 32'h201);

        // 6 cleared board after a win
        clear_board();
        scan(nb, nd, da);
`ifdef GO_ENCODE_STICKY_EN
        chk("t6_busy_cycles", 32'(nb), 32'd0);
        chk("t6_done_count", 32'(nd), 32'd0);
        chk("t6_gameover", 32'(gameover), 32'h201);
`else
        chk("t6_busy_cycles", 32'(nb), 32'd11);
        chk("t6_done_count", 32'(nd), 32'd1);
        chk("t6_gameover", 32'(gameover), 32'h000);
`endif
        repeat (2) @(negedge clk);
        armed = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
